// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared defaults, address-width helper and slot type for reg_write_ctrl
// Purpose: default sizing for the register-file write controller and the
//          address-width clamp shared by the controller, its interface and decoder.
// Ports:   none (package).
package reg_ctrl_pkg;

    localparam int NUM_REGS_DEF  = 15;
    localparam int NUM_PORTS_DEF = 2;
    localparam int DATA_W_DEF    = 32;

    // $clog2 returns 0 for a single entry; an index still needs one bit.
    function automatic int clamp_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int AW_DEF = clamp_aw(NUM_REGS_DEF);

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

endpackage

// File: rtl/reg_write_ctrl_if.sv
// rtl/reg_write_ctrl_if.sv - write-request and register-file bundle for reg_write_ctrl
// Purpose: groups the per-port write handshakes and the register-file outputs.
// Signals: wr_valid/wr_ready/wr_addr/wr_data (per port request handshake),
//          reg_en/reg_wdata (registered per-register enables and data),
//          wr_err (per port out-of-range drop pulse), busy (any slot occupied).
// Modports: master = write-back side driving requests; slave = the controller.
interface reg_write_ctrl_if
    import reg_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int AW        = clamp_aw(NUM_REGS)
);

    logic [NUM_PORTS-1:0]             wr_valid;
    logic [NUM_PORTS-1:0]             wr_ready;
    logic [NUM_PORTS-1:0][AW-1:0]     wr_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wr_data;
    logic [NUM_REGS-1:0]              reg_en;
    logic [NUM_REGS-1:0][DATA_W-1:0]  reg_wdata;
    logic [NUM_PORTS-1:0]             wr_err;
    logic                             busy;

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, reg_en, reg_wdata, wr_err, busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, reg_en, reg_wdata, wr_err, busy
    );

endinterface

// File: rtl/reg_onehot_dec.sv
// rtl/reg_onehot_dec.sv - register address to one-hot decoder with range flag
// Purpose: turns a slot address into a one-hot register select.
// Ports:   addr_i     - register address
//          onehot_o   - one-hot select, all zero when out of range
//          in_range_o - address below NUM_REGS
module reg_onehot_dec
    import reg_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int AW       = clamp_aw(NUM_REGS)
) (
    input  logic [AW-1:0]       addr_i,
    output logic [NUM_REGS-1:0] onehot_o,
    output logic                in_range_o
);

    always_comb begin
        onehot_o   = '0;
        in_range_o = (32'(addr_i) < 32'(NUM_REGS));
        for (int r = 0; r < NUM_REGS; r++) begin
            if (32'(addr_i) == 32'(r)) begin
                onehot_o[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_ctrl.sv
// rtl/reg_write_ctrl.sv - multi-port register-file write controller with round-robin conflict resolution
// Purpose: buffers one write per port, grants non-conflicting writes in parallel,
//          resolves same-register conflicts round-robin and drives registered enables.
// Ports:   clk   - clock, all state on rising edge
//          reset - synchronous active-high reset
//          stall - freeze grants and drops; slots hold
//          bus   - slave side of reg_write_ctrl_if (requests in, register-file outputs)
module reg_write_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    reg_write_ctrl_if.slave  bus
);

    localparam int AW = clamp_aw(NUM_REGS);
    localparam int PW = clamp_aw(NUM_PORTS);

    logic [NUM_PORTS-1:0]              slot_valid_q, slot_valid_d;
    logic [NUM_PORTS-1:0][AW-1:0]      slot_addr_q, slot_addr_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  slot_data_q, slot_data_d;
    logic [PW-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [NUM_REGS-1:0]               reg_en_q, reg_en_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic [NUM_PORTS-1:0]              wr_err_q, wr_err_d;

    logic [NUM_PORTS-1:0][NUM_REGS-1:0] onehot;
    logic [NUM_PORTS-1:0]               in_range;
    logic [NUM_PORTS-1:0]               grant;
    logic [NUM_PORTS-1:0]               drop;
    logic [NUM_PORTS-1:0]               ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        reg_onehot_dec #(
            .NUM_REGS (NUM_REGS),
            .AW       (AW)
        ) u_dec (
            .addr_i     (slot_addr_q[p]),
            .onehot_o   (onehot[p]),
            .in_range_o (in_range[p])
        );
    end

    // Cyclic distance from the round-robin pointer; smaller wins.
    function automatic int rr_dist(input int q, input logic [PW-1:0] rr);
        return (q + NUM_PORTS - int'(rr)) % NUM_PORTS;
    endfunction

    always_comb begin
        int   dp;
        int   best;
        logic win;
        logic conf;
        grant    = '0;
        drop     = '0;
        rr_ptr_d = rr_ptr_q;
        best     = NUM_PORTS;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dp   = rr_dist(p, rr_ptr_q);
            win  = 1'b1;
            conf = 1'b0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q != p && slot_valid_q[q] && in_range[q] &&
                    slot_addr_q[q] == slot_addr_q[p]) begin
                    conf = 1'b1;
                    if (rr_dist(q, rr_ptr_q) < dp) begin
                        win = 1'b0;
                    end
                end
            end
            if (!stall && slot_valid_q[p]) begin
                if (!in_range[p]) begin
                    drop[p] = 1'b1;
                end else if (win) begin
                    grant[p] = 1'b1;
                    // With several conflicted registers in one cycle, the
                    // winner nearest the pointer decides where it moves.
                    if (conf && dp < best) begin
                        best     = dp;
                        rr_ptr_d = PW'((p + 1) % NUM_PORTS);
                    end
                end
            end
        end
    end

    // A slot freed this cycle may take a new request on the same edge.
    assign ready = ~slot_valid_q | grant | drop;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_data_d  = slot_data_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.wr_valid[p] && ready[p]) begin
                slot_valid_d[p] = 1'b1;
                slot_addr_d[p]  = bus.wr_addr[p];
                slot_data_d[p]  = bus.wr_data[p];
            end else if (grant[p] || drop[p]) begin
                slot_valid_d[p] = 1'b0;
            end
        end
    end

    always_comb begin
        reg_en_d    = '0;
        reg_wdata_d = reg_wdata_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p] && onehot[p][r]) begin
                    reg_en_d[r]    = 1'b1;
                    reg_wdata_d[r] = slot_data_q[p];
                end
            end
        end
        wr_err_d = drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_q <= '0;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
            rr_ptr_q     <= '0;
            reg_en_q     <= '0;
            reg_wdata_q  <= '0;
            wr_err_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
            rr_ptr_q     <= rr_ptr_d;
            reg_en_q     <= reg_en_d;
            reg_wdata_q  <= reg_wdata_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign bus.wr_ready  = ready;
    assign bus.reg_en    = reg_en_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.busy      = |slot_valid_q;

endmodule
